// File: rtl/lfsr_checker_param_if.sv
// Bundle of the checker's data-side signals (stream in, status out).
// The slave modport is the checker's view; the master modport is the source/monitor side.
interface lfsr_checker_param_if #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 16
);
  logic                 i_soft_reset;
  logic                 i_valid;
  logic [WIDTH-1:0]     i_data;
  logic                 o_lock;
  logic                 o_valid;
  logic                 o_match;
  logic                 o_err;
  logic [ERR_CNT_W-1:0] o_err_cnt;

  modport slave (
    input  i_soft_reset, i_valid, i_data,
    output o_lock, o_valid, o_match, o_err, o_err_cnt
  );

  modport master (
    output i_soft_reset, i_valid, i_data,
    input  o_lock, o_valid, o_match, o_err, o_err_cnt
  );
endinterface

// File: rtl/lfsr_checker_param.sv
// Self-synchronising Fibonacci LFSR sequence checker.
// While unlocked it reseeds its prediction from every received word; once enough
// consecutive predictions hit it locks and flywheels its own sequence, dropping
// lock only after a run of consecutive misses.
// Optional saturating error counter: define LFSR_CHK_ERRCNT_EN to build it;
// otherwise o_err_cnt is tied to zero.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_UNLOCKED | searching: reload prediction from data, count hits to lock
// ST_LOCKED   | tracking: prediction free-runs, count misses to unlock
module lfsr_checker_param #(
  parameter int              WIDTH             = 16,
  parameter logic [WIDTH-1:0] POLY             = 16'hB400,
  parameter int              VALID_TO_LOCK     = 5,
  parameter int              INVALID_TO_UNLOCK = 3,
  parameter int              ERR_CNT_W         = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lfsr_checker_param_if.slave  bus
);

  localparam int MAXC = (VALID_TO_LOCK > INVALID_TO_UNLOCK) ? VALID_TO_LOCK : INVALID_TO_UNLOCK;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] V2L_M1 = CW'(VALID_TO_LOCK - 1);
  localparam logic [CW-1:0] I2U_M1 = CW'(INVALID_TO_UNLOCK - 1);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_expect, w_expect_nxt;
  logic             r_ref, w_ref_nxt;
  logic [CW-1:0]    r_vcnt, w_vcnt_nxt;
  logic [CW-1:0]    r_icnt, w_icnt_nxt;
  logic             r_lock, w_lock_nxt;
  logic             r_valid;
  logic             r_match, w_match_nxt;
  logic             r_err, w_err_nxt;

  logic [WIDTH-1:0] w_data;
  logic             w_data_nz;
  logic             w_eq;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & POLY)};
  endfunction

  assign w_data    = bus.i_data;
  assign w_data_nz = |w_data;
  assign w_eq      = (w_data == r_expect);

  // Next-state and per-word flag decode; everything holds on idle cycles.
  always_comb begin
    w_state_nxt  = r_state;
    w_expect_nxt = r_expect;
    w_ref_nxt    = r_ref;
    w_vcnt_nxt   = r_vcnt;
    w_icnt_nxt   = r_icnt;
    w_lock_nxt   = r_lock;
    w_match_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    if (bus.i_valid) begin
      case (r_state)
        ST_UNLOCKED: begin
          // all-zero is the LFSR lock-up state, so it can never seed or confirm
          w_expect_nxt = lfsr_next(w_data);
          w_ref_nxt    = w_data_nz;
          if (r_ref && w_eq && w_data_nz) begin
            w_match_nxt = 1'b1;
            if (r_vcnt == V2L_M1) begin
              w_state_nxt = ST_LOCKED;
              w_lock_nxt  = 1'b1;
              w_vcnt_nxt  = '0;
            end else begin
              w_vcnt_nxt = r_vcnt + 1'b1;
            end
          end else begin
            w_vcnt_nxt = '0;
          end
        end
        ST_LOCKED: begin
          w_expect_nxt = lfsr_next(r_expect);
          if (w_eq) begin
            w_match_nxt = 1'b1;
            w_icnt_nxt  = '0;
          end else begin
            w_err_nxt = 1'b1;
            if (r_icnt == I2U_M1) begin
              // fall back to search, seeding from the word that broke lock
              w_state_nxt  = ST_UNLOCKED;
              w_lock_nxt   = 1'b0;
              w_icnt_nxt   = '0;
              w_vcnt_nxt   = '0;
              w_expect_nxt = lfsr_next(w_data);
              w_ref_nxt    = w_data_nz;
            end else begin
              w_icnt_nxt = r_icnt + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  // State, prediction and registered per-word outputs; soft reset beats i_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_UNLOCKED;
      r_expect <= '0;
      r_ref    <= 1'b0;
      r_vcnt   <= '0;
      r_icnt   <= '0;
      r_lock   <= 1'b0;
      r_valid  <= 1'b0;
      r_match  <= 1'b0;
      r_err    <= 1'b0;
    end else if (bus.i_soft_reset) begin
      r_state  <= ST_UNLOCKED;
      r_expect <= '0;
      r_ref    <= 1'b0;
      r_vcnt   <= '0;
      r_icnt   <= '0;
      r_lock   <= 1'b0;
      r_valid  <= 1'b0;
      r_match  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_expect <= w_expect_nxt;
      r_ref    <= w_ref_nxt;
      r_vcnt   <= w_vcnt_nxt;
      r_icnt   <= w_icnt_nxt;
      r_lock   <= w_lock_nxt;
      r_valid  <= bus.i_valid;
      r_match  <= w_match_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.o_lock  = r_lock;
  assign bus.o_valid = r_valid;
  assign bus.o_match = r_match;
  assign bus.o_err   = r_err;

`ifdef LFSR_CHK_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating count of locked mismatches, updated on the same edge as o_err.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (bus.i_soft_reset) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.o_err_cnt = r_err_cnt;
`else
  assign bus.o_err_cnt = '0;
`endif

endmodule
